// File: rtl/rf_ctrl_pkg.sv
// Shared types and constants for the register-file write arbiter.
package rf_ctrl_pkg;

    localparam int PW      = 4;
    localparam int NREG    = 2 ** PW;

    localparam int REQ_ALU = 0;
    localparam int REQ_LD  = 1;

    typedef struct packed {
        logic [PW-1:0] addr;
        logic [7:0]    data;
    } wr_req_t;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Producer-side write handshakes (ALU writeback and load path).
interface rf_write_arbiter_if;
    import rf_ctrl_pkg::*;

    logic          alu_valid;
    logic [PW-1:0] alu_addr;
    logic [7:0]    alu_data;
    logic          alu_ready;

    logic          ld_valid;
    logic [PW-1:0] ld_addr;
    logic [7:0]    ld_data;
    logic          ld_ready;

    modport master (
        output alu_valid, alu_addr, alu_data,
        output ld_valid, ld_addr, ld_data,
        input  alu_ready, ld_ready
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  ld_valid, ld_addr, ld_data,
        output alu_ready, ld_ready
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the last winner loses the next tie.
module rr_arb2
    import rf_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    logic last_grant;

    always_comb begin
        // NOTE: default every always_comb output first so no path can infer a latch.
        grant = '0;
        if (req[REQ_ALU] && (!req[REQ_LD] || last_grant == 1'(REQ_LD)))
            grant[REQ_ALU] = 1'b1;
        else if (req[REQ_LD])
            grant[REQ_LD] = 1'b1;
    end

    // Reset to LD so the ALU wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
        if (reset)
            last_grant <= 1'(REQ_LD);
        else if (accept)
            last_grant <= grant[REQ_LD];
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between ALU and load producers and
// tracks per-register busy state for read-after-write hazard detection.
module rf_write_arbiter
    import rf_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    rf_write_arbiter_if.slave bus,
    input  logic            mark_en,
    input  logic [PW-1:0]   mark_addr,
    input  logic            flush,
    input  logic [PW-1:0]   rd_addrA,
    input  logic [PW-1:0]   rd_addrB,
    output logic            hazardA,
    output logic            hazardB,
    output logic            wr_en,
    output logic [PW-1:0]   wr_addr,
    output logic [7:0]      wr_data,
    output logic [NREG-1:0] busy
);

    logic [1:0]      req;
    logic [1:0]      grant;
    logic            transfer;
    wr_req_t         sel;
    logic [NREG-1:0] busy_next;

    // Requests are masked during reset so readies drop the moment reset rises.
    assign req[REQ_ALU] = bus.alu_valid & ~reset;
    assign req[REQ_LD]  = bus.ld_valid  & ~reset;

    rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .accept (transfer),
        .grant  (grant)
    );

    assign transfer      = |grant;
    assign bus.alu_ready = grant[REQ_ALU];
    assign bus.ld_ready  = grant[REQ_LD];

    always_comb begin
        if (grant[REQ_LD])
            sel = '{addr: bus.ld_addr, data: bus.ld_data};
        else
            sel = '{addr: bus.alu_addr, data: bus.alu_data};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= transfer;
            if (transfer) begin
                wr_addr <= sel.addr;
                wr_data <= sel.data;
            end
        end
    end

    // Order matters: flush, then clear on write, then mark so a newer reservation wins.
    always_comb begin
        busy_next = busy;
        if (flush)
            busy_next = '0;
        if (transfer)
            busy_next[sel.addr] = 1'b0;
        if (mark_en)
            busy_next[mark_addr] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            busy <= '0;
        else
            busy <= busy_next;
    end

    // The wr_en term covers the cycle the write is still in flight to the file.
    assign hazardA = busy[rd_addrA] || (wr_en && wr_addr == rd_addrA);
    assign hazardB = busy[rd_addrB] || (wr_en && wr_addr == rd_addrB);

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the single register-file write port between two producers: the ALU writeback path and the load path. It uses round-robin arbitration with a valid/ready handshake per producer. It also keeps a per-register busy scoreboard so the issue stage can detect read-after-write hazards on the two register-file read ports. It sits between the execute/load stages and the register file and drives the register file's write-enable, write-address and write-data inputs directly.

## Interface
- pw, 4, register address width; 2**pw registers
- clk  in  1  clock, all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state
- alu_valid  in  1  ALU write request present
- alu_addr  in  pw  ALU destination register
- alu_data  in  8  ALU result
- alu_ready  out  1  ALU request accepted this cycle
- ld_valid  in  1  load write request present
- ld_addr  in  pw  load destination register
- ld_data  in  8  load data
- ld_ready  out  1  load request accepted this cycle
- mark_en  in  1  issue stage reserves a destination register
- mark_addr  in  pw  register to mark busy
- flush  in  1  clear all busy bits (pipeline squash)
- rd_addrA, rd_addrB  in  pw  read addresses being issued
- hazardA, hazardB  out  1  corresponding read would see stale data
- wr_en  out  1  register-file write enable (registered)
- wr_addr  out  pw  register-file write address (registered)
- wr_data  out  8  register-file write data (registered)
- busy  out  2**pw  scoreboard bit vector

## Operation
- **Handshake:** a transfer occurs when valid && ready. A producer holds addr/data stable while valid && !ready. ready is combinational from both valids and the priority state. ready is never asserted without a matching valid.
- **Arbitration:**
  - Only one producer valid: that producer is granted.
  - Both valid: the producer not granted last is granted.
  - last_grant updates only on a transfer. Reset value is LD, so the ALU wins the first tie.
- **Write output:** on a transfer, wr_en, wr_addr and wr_data load the granted request at the same edge. Otherwise wr_en is 0 next cycle, and wr_addr/wr_data hold their values.
- **Scoreboard:**
  - mark_en sets busy[mark_addr].
  - A transfer clears busy[granted addr].
  - Set and clear on the same address in the same cycle: set wins (a newer producer is outstanding).
  - flush clears all bits. flush together with mark_en: the mark still applies.
  - A write to a non-busy register is legal and leaves the bit 0.
- **Hazard (combinational):** hazardX = busy[rd_addrX] || (wr_en && wr_addr == rd_addrX). The second term covers the one cycle in which the write is in flight to the register file and not yet stored.
- **Reset, asynchronous, any time:**
  - busy = 0, wr_en = 0, wr_addr = 0, wr_data = 0, last_grant = LD.
  - A request in progress at reset is dropped; the producer must re-present it.

## Timing
- Throughput: one write per cycle sustained; no bubbles between back-to-back grants.
- Latency:
  - Request accepted at edge N → wr_en high in cycle N..N+1.
  - The register file stores the data at edge N+1.
  - Readable without hazard from cycle N+1..N+2.
- busy clears at edge N. hazard stays high through cycle N..N+1 via the wr_en term.
- A producer that waits is granted within 2 cycles while it stays valid (no starvation).
- Outputs after reset deassertion: alu_ready = ld_ready = 0 until a valid arrives; hazardA = hazardB = 0.

## Structure
- **Package rf_ctrl_pkg:**
  - Default PW = 4.
  - Requester index constants REQ_ALU = 0, REQ_LD = 1.
  - Typedef wr_req_t, a struct with addr[PW-1:0] and data[7:0].
- **Sub-module rr_arb2:** two-input round-robin arbiter.
  - Inputs: req[1:0], accept.
  - Output: one-hot grant[1:0].
  - Owns the last_grant flop and its asynchronous reset.
- **Top level:** the write-output register, the busy vector and the hazard compare.

## Test plan
- **Single ALU write:** alu_valid = 1, addr = 3, data = 0x5A, register 3 marked beforehand. Required:
  - alu_ready = 1 in the same cycle.
  - Next cycle: wr_en = 1, wr_addr = 3, wr_data = 0x5A.
  - busy[3] = 0.
  - hazardA (rd_addrA = 3) = 1 for exactly one more cycle, then 0.
- **Tie and alternation:** both valid for 4 cycles (ALU addr 1, LD addr 2). Required:
  - Grants ALU, LD, ALU, LD.
  - wr_addr sequence 1, 2, 1, 2.
  - wr_en held high.
- **Mark/clear collision:** mark_en with addr 5 in the same cycle as an accepted write to 5. Required: busy[5] = 1 afterwards.
- **Flush with mark:** busy = 0x00F0, then flush with mark_en addr 9 in one cycle. Required: busy = 0x0200.
- **Stall hold:** LD valid and held stable while the ALU is granted. Required:
  - ld_ready = 0, then 1 on the next cycle.
  - LD data written unchanged.
- **Reset mid-stream:** assert reset asynchronously between edges while wr_en = 1 and busy = 0x0011. Required:
  - wr_en, busy, hazards and readies drop to 0 immediately.
  - After release, the first tie goes to the ALU.
